// File: rtl/ped_pkg.sv
// Shared types and helpers for the pedestrian crossing controller and its bench.
package ped_pkg;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_REQ   = 3'd1;
  localparam logic [2:0] ENC_WALK  = 3'd2;
  localparam logic [2:0] ENC_FLASH = 3'd3;
  localparam logic [2:0] ENC_CLEAR = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ENC_IDLE,
    ST_REQ   = ENC_REQ,
    ST_WALK  = ENC_WALK,
    ST_FLASH = ENC_FLASH,
    ST_CLEAR = ENC_CLEAR
  } ped_state_e;

  // Width of a counter that must reach max_val-1; never less than one bit.
  function automatic int unsigned ped_cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/pedestrian_crossing_ctrl_if.sv
// Lamp/request bundle between the pedestrian controller and the vehicle light.
// The chirp signal exists only when PED_AUDIO_EN is defined.
interface pedestrian_crossing_ctrl_if;

  logic red;
  logic green;
  logic yellow;
  logic pedstrian_button;
  logic walk;
  logic dont_walk;
  logic req_pending;
`ifdef PED_AUDIO_EN
  logic chirp;
`endif

`ifdef PED_AUDIO_EN
  modport master (
    input  red, green, yellow,
    output pedstrian_button, walk, dont_walk, req_pending, chirp
  );
  modport slave (
    output red, green, yellow,
    input  pedstrian_button, walk, dont_walk, req_pending, chirp
  );
`else
  modport master (
    input  red, green, yellow,
    output pedstrian_button, walk, dont_walk, req_pending
  );
  modport slave (
    output red, green, yellow,
    input  pedstrian_button, walk, dont_walk, req_pending
  );
`endif

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; emits a one-cycle rise pulse
// (combinational, aligned with the edge that accepts the new level).
module btn_debounce
  import ped_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic rise_o
);

  localparam int unsigned DB_W = ped_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES must be non-zero");
  end

  logic [1:0]      sync_q, sync_d;
  logic            db_q, db_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], btn_raw};
    db_d   = db_q;
    cnt_d  = '0;
    rise_o = 1'b0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == DB_LAST) begin
        db_d   = sync_q[1];
        rise_o = sync_q[1];
      end else begin
        cnt_d = cnt_q + DB_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/pedestrian_crossing_ctrl.sv
// Pedestrian-side partner of one_lane_traffic_light: debounced request, WALK /
// flashing DON'T-WALK sequencing slaved to the vehicle lamps. PED_AUDIO_EN adds chirp.
module pedestrian_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WALK_CYCLES     = 100,
  parameter int unsigned FLASH_CYCLES    = 60,
  parameter int unsigned FLASH_HALF      = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        btn_raw,
  pedestrian_crossing_ctrl_if.master  ped
);

  localparam int unsigned CNT_MAX = (WALK_CYCLES > FLASH_CYCLES) ? WALK_CYCLES : FLASH_CYCLES;
  localparam int unsigned CNT_W   = ped_cnt_w(CNT_MAX);
  localparam int unsigned HALF_W  = ped_cnt_w(FLASH_HALF);

  localparam logic [CNT_W-1:0]  WALK_LAST  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(FLASH_HALF - 1);
  localparam logic [HALF_W-1:0] HALF_ONE   = HALF_W'(1);

  if (WALK_CYCLES == 0) begin : g_bad_walk
    $error("pedestrian_crossing_ctrl: WALK_CYCLES must be non-zero");
  end
  if (FLASH_CYCLES == 0) begin : g_bad_flash
    $error("pedestrian_crossing_ctrl: FLASH_CYCLES must be non-zero");
  end
  if (FLASH_HALF == 0) begin : g_bad_half
    $error("pedestrian_crossing_ctrl: FLASH_HALF must be non-zero");
  end

  ped_state_e        state_q, state_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              walk_q, walk_d;
  logic              dont_walk_q, dont_walk_d;
  logic              ped_btn_q, ped_btn_d;
  logic              safe_red;
  logic              enter;
  logic              btn_rise;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .rise_o  (btn_rise)
  );

  always_comb begin
    safe_red = ped.red & ~ped.green & ~ped.yellow;
    state_d  = state_q;
    pend_d   = pend_q;
    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    half_d   = (half_q == HALF_LAST) ? '0 : half_q + HALF_ONE;

    // Presses while already being served (REQ, WALK) are absorbed.
    if (btn_rise && (state_q inside {ST_IDLE, ST_FLASH, ST_CLEAR})) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (safe_red) begin
          state_d = ST_WALK;
          pend_d  = 1'b0;
        end
      end
      ST_WALK: begin
        if (!safe_red)              state_d = ST_CLEAR;
        else if (cnt_q == WALK_LAST) state_d = ST_FLASH;
      end
      ST_FLASH: begin
        if (!safe_red || cnt_q == FLASH_LAST) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        // Leave only once the light has dropped red so one red is served once.
        if (!safe_red) state_d = pend_q ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    enter = (state_d != state_q);
    if (enter) begin
      cnt_d  = '0;
      half_d = '0;
    end

    // Outputs are registered, decoded from the state being entered.
    walk_d      = (state_d == ST_WALK);
    ped_btn_d   = (state_d == ST_REQ);
    dont_walk_d = 1'b1;
    if (state_d == ST_WALK) begin
      dont_walk_d = 1'b0;
    end else if (state_d == ST_FLASH) begin
      if (enter)                  dont_walk_d = 1'b1;
      else if (half_q == HALF_LAST) dont_walk_d = ~dont_walk_q;
      else                        dont_walk_d = dont_walk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      half_q      <= '0;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
      ped_btn_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
      ped_btn_q   <= ped_btn_d;
    end
  end

  assign ped.walk             = walk_q;
  assign ped.dont_walk        = dont_walk_q;
  assign ped.pedstrian_button = ped_btn_q;
  assign ped.req_pending      = pend_q | (state_q == ST_REQ);

`ifdef PED_AUDIO_EN
  logic chirp_q, chirp_d;

  always_comb begin
    chirp_d = 1'b0;
    if (state_d == ST_WALK && !enter) begin
      chirp_d = (half_q == HALF_LAST) ? ~chirp_q : chirp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) chirp_q <= 1'b0;
    else        chirp_q <= chirp_d;
  end

  assign ped.chirp = chirp_q;
`endif

endmodule

// File: tb/tb_pedestrian_crossing_ctrl.sv
// Directed bench for pedestrian_crossing_ctrl; checks chirp too when PED_AUDIO_EN is defined.
module tb_pedestrian_crossing_ctrl;
  import ped_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  pedestrian_crossing_ctrl_if pif();

  pedestrian_crossing_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .WALK_CYCLES    (100),
    .FLASH_CYCLES   (60),
    .FLASH_HALF     (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .ped     (pif)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic lights(input logic r, input logic g, input logic y);
    pif.red    = r;
    pif.green  = g;
    pif.yellow = y;
  endtask

  // Each tick ends on the falling edge after one rising edge; inputs are changed there too.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_lamps(input string tag, input logic w, input logic dw,
                             input logic pb, input logic rp);
    check_eq({tag, ".walk"},        pif.walk,             w);
    check_eq({tag, ".dont_walk"},   pif.dont_walk,        dw);
    check_eq({tag, ".ped_button"},  pif.pedstrian_button, pb);
    check_eq({tag, ".req_pending"}, pif.req_pending,      rp);
  endtask

  task automatic check_chirp(input string tag, input logic exp);
`ifdef PED_AUDIO_EN
    check_eq({tag, ".chirp"}, pif.chirp, exp);
`else
    if (exp) begin end
    if (tag.len() == 0) begin end
`endif
  endtask

  bit bounce [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0;
    btn_raw = 1'b1;
    lights(1'b0, 1'b1, 1'b0);

    // Reset held with the button pressed
    for (int k = 0; k < 3; k++) begin
      tick();
      check_lamps($sformatf("rst%0d", k), 1'b0, 1'b1, 1'b0, 1'b0);
      check_chirp("rst", 1'b0);
    end
    rst_n = 1'b1;
    btn_raw = 1'b0;
    repeat (4) tick();
    check_lamps("idle", 1'b0, 1'b1, 1'b0, 1'b0);

    // Long press on green: pend at edge 6, REQ at edge 7
    btn_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_eq($sformatf("press.req_pending@%0d", k), pif.req_pending, k >= 6);
      check_eq($sformatf("press.ped_button@%0d", k), pif.pedstrian_button, k >= 7);
      check_eq($sformatf("press.walk@%0d", k), pif.walk, 1'b0);
    end
    btn_raw = 1'b0;
    repeat (8) begin
      tick();
      check_lamps("req_hold", 1'b0, 1'b1, 1'b1, 1'b1);
    end

    // Red only: WALK for exactly 100 cycles
    lights(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      tick();
      check_lamps($sformatf("walk@%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
      check_chirp($sformatf("walk@%0d", k), (((k - 1) / 5) % 2) == 1);
    end

    // FLASH: 60 cycles, toggle every 5; press during it sets pend
    for (int i = 0; i < 60; i++) begin
      tick();
      check_eq($sformatf("flash.walk@%0d", i), pif.walk, 1'b0);
      check_eq($sformatf("flash.dont_walk@%0d", i), pif.dont_walk, ((i / 5) % 2) == 0);
      check_eq($sformatf("flash.req_pending@%0d", i), pif.req_pending, i >= 26);
      check_chirp("flash", 1'b0);
      if (i == 20) btn_raw = 1'b1;
      if (i == 30) btn_raw = 1'b0;
    end

    // CLEAR holds while the same red persists
    repeat (5) begin
      tick();
      check_lamps("clear_hold", 1'b0, 1'b1, 1'b0, 1'b1);
    end
    lights(1'b0, 1'b1, 1'b0);
    tick();
    check_lamps("req_again", 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (5) begin
      tick();
      check_lamps("req_again_hold", 1'b0, 1'b1, 1'b1, 1'b1);
    end

    // Second WALK on a new red, aborted at cycle 40 by green
    lights(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      check_eq($sformatf("walk2@%0d", k), pif.walk, 1'b1);
    end
    lights(1'b1, 1'b1, 1'b0);
    tick();
    check_lamps("abort", 1'b0, 1'b1, 1'b0, 1'b0);
    check_chirp("abort", 1'b0);
    tick();
    lights(1'b0, 1'b1, 1'b0);
    repeat (5) begin
      tick();
      check_lamps("post_abort_green", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    lights(1'b1, 1'b0, 1'b0);
    repeat (10) begin
      tick();
      check_lamps("idle_on_red", 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Bounce 1-0-1 with 2-cycle pulses is rejected
    lights(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      btn_raw = bounce[i];
      tick();
      check_lamps($sformatf("bounce@%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // 3-cycle pulse (one short of the debounce window) is rejected
    btn_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) btn_raw = 1'b0;
      check_lamps($sformatf("glitch3@%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // 4-cycle pulse is accepted with the 6-cycle latency
    btn_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq($sformatf("p4.req_pending@%0d", k), pif.req_pending, k >= 6);
      check_eq($sformatf("p4.ped_button@%0d", k), pif.pedstrian_button, k >= 7);
      if (k == 4) btn_raw = 1'b0;
    end

    // Illegal lamp combinations never count as red
    lights(1'b1, 1'b0, 1'b1);
    repeat (10) begin
      tick();
      check_lamps("red_yellow", 1'b0, 1'b1, 1'b1, 1'b1);
    end
    lights(1'b0, 1'b0, 1'b0);
    repeat (3) begin
      tick();
      check_lamps("all_off", 1'b0, 1'b1, 1'b1, 1'b1);
    end
    lights(1'b1, 1'b1, 1'b1);
    repeat (3) begin
      tick();
      check_lamps("all_on", 1'b0, 1'b1, 1'b1, 1'b1);
    end
    lights(1'b1, 1'b0, 1'b0);
    tick();
    check_lamps("walk3", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Reset mid-WALK aborts on that edge
    rst_n = 1'b0;
    tick();
    check_lamps("rst_mid", 1'b0, 1'b1, 1'b0, 1'b0);
    check_chirp("rst_mid", 1'b0);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check_lamps("post_rst", 1'b0, 1'b1, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
